snn_neuron_scheduler: RTL and testbench

//  Time-multiplexed IF-neuron core. One shared integrate/threshold datapath serves NUM_NEURONS virtual neurons.

---
 rtl/snn_pkg.sv | 19 +
 rtl/snn_rr_arbiter.sv | 37 +++
 rtl/snn_neuron_scheduler.sv | 129 ++++++++++++
 tb/tb_snn_neuron_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the time-multiplexed IF-neuron core.
// Imported by snn_rr_arbiter and snn_neuron_scheduler.
package snn_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  localparam int unsigned DEF_CUR_W     = 16;
  localparam int unsigned DEF_THRESHOLD = 32'h0000_8000;
  localparam int unsigned DEF_RESET_POT = 32'h0000_0000;

  // Index width for n items; never below 1 so single-entry vectors stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after the pointer,
// searching upward with wrap. No grant when enable is low.
module snn_rr_arbiter
  import snn_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic            enable,
  input  logic [ID_W-1:0] pointer,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  logic            found;
  int unsigned     cand;
  logic [ID_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(pointer) + k) % N;
      cand_idx = ID_W'(cand);
      if (!found && enable && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed IF-neuron core: round-robin current intake, shared
// integrate/threshold datapath, spike events over valid/ready.
// Optional refractory counters are enabled by defining SNN_REFRACTORY_EN.
module snn_neuron_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned       NUM_NEURONS = 4,
  parameter int unsigned       CUR_W       = DEF_CUR_W,
  parameter logic [CUR_W-1:0]  THRESHOLD   = CUR_W'(DEF_THRESHOLD),
  parameter logic [CUR_W-1:0]  RESET_POT   = CUR_W'(DEF_RESET_POT),
  parameter int unsigned       REFRACT_CYC = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_NEURONS-1:0]             req,
  input  logic [NUM_NEURONS*CUR_W-1:0]       cur,
  output logic [NUM_NEURONS-1:0]             grant,
  input  logic                               clear_pot,
  output logic                               spike_valid,
  output logic [id_width(NUM_NEURONS)-1:0]   spike_id,
  input  logic                               spike_ready,
  output logic                               busy
);

  localparam int unsigned ID_W = id_width(NUM_NEURONS);

  state_t            state;
  state_t            state_nxt;
  logic [CUR_W-1:0]  pot [NUM_NEURONS];
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cur_id;
  logic [CUR_W-1:0]  cur_lat;

  logic              slot_free;
  logic              arb_en;
  logic [ID_W-1:0]   arb_idx;
  logic              take;
  logic [CUR_W:0]    sum_raw;
  logic [CUR_W-1:0]  sum_sat;
  logic              hit;
  logic              skip;

  assign slot_free = !spike_valid || spike_ready;
  assign arb_en    = (state == IDLE) && slot_free && !clear_pot && !rst;

  snn_rr_arbiter #(
    .N    (NUM_NEURONS),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req),
    .enable  (arb_en),
    .pointer (ptr),
    .grant   (grant),
    .idx     (arb_idx)
  );

  assign take    = |(req & grant);
  assign sum_raw = {1'b0, pot[cur_id]} + {1'b0, cur_lat};
  assign sum_sat = sum_raw[CUR_W] ? '1 : sum_raw[CUR_W-1:0];
  assign hit     = sum_sat >= THRESHOLD;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == UPDATE) && !rst;
    case (state)
      IDLE:    if (take) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_pot) state_nxt = IDLE;
  end

`ifdef SNN_REFRACTORY_EN
  localparam int unsigned REFR_W = id_width(REFRACT_CYC + 1);
  logic [REFR_W-1:0] refr [NUM_NEURONS];

  assign skip = refr[cur_id] != '0;

  always_ff @(posedge clk) begin
    if (rst || clear_pot) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) refr[i] <= '0;
    end else if (state == UPDATE) begin
      if (skip)     refr[cur_id] <= refr[cur_id] - 1'b1;
      else if (hit) refr[cur_id] <= REFR_W'(REFRACT_CYC);
    end
  end
`else
  assign skip = 1'b0;
`endif

  // The handshake clear comes first so a slot freed at a grant edge cannot
  // race with the spike raised by the following UPDATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) pot[i] <= RESET_POT;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      ptr         <= ID_W'(NUM_NEURONS - 1);
      cur_id      <= '0;
      cur_lat     <= '0;
    end else begin
      if (spike_valid && spike_ready) spike_valid <= 1'b0;
      if (clear_pot) begin
        for (int unsigned i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
      end else begin
        if (state == IDLE && take) begin
          cur_id  <= arb_idx;
          cur_lat <= cur[arb_idx*CUR_W +: CUR_W];
          ptr     <= arb_idx;
        end
        if (state == UPDATE && !skip) begin
          if (hit) begin
            pot[cur_id] <= RESET_POT;
            spike_valid <= 1'b1;
            spike_id    <= cur_id;
          end else begin
            pot[cur_id] <= sum_sat;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// Directed self-checking bench for snn_neuron_scheduler (NUM_NEURONS=4, defaults).
module tb_snn_neuron_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] cur;
  logic [3:0]  grant;
  logic        clear_pot;
  logic        spike_valid;
  logic [1:0]  spike_id;
  logic        spike_ready;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  snn_neuron_scheduler #(
    .NUM_NEURONS (4),
    .CUR_W       (16),
    .THRESHOLD   (16'h8000),
    .RESET_POT   (16'h0000),
    .REFRACT_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .cur         (cur),
    .grant       (grant),
    .clear_pot   (clear_pot),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transfer for requester id: wait for grant, then the UPDATE cycle.
  task automatic xfer(input int id, input logic [15:0] val);
    bit got;
    got = 1'b0;
    req[id] = 1'b1;
    cur[id*16 +: 16] = val;
    for (int t = 0; t < 16 && !got; t++) begin
      #1;
      if (grant[id]) got = 1'b1;
      else tick();
    end
    if (!got) check("xfer_timeout", 32'd0, 32'd1);
    tick();
    req[id] = 1'b0;
    check("xfer_busy", 32'(busy), 32'd1);
    tick();
  endtask

  initial begin
    req = '0; cur = '0; clear_pot = 1'b0; spike_ready = 1'b0;

    // Reset: grant and busy held low even with every requester active.
    rst = 1'b1;
    req = 4'b1111;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    req = '0;
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(spike_valid), 32'd0);
    check("rst_id", 32'(spike_id), 32'd0);
    check("rst_pot0", 32'(dut.pot[0]), 32'h0);

    // 1: two 0x4000 transfers on neuron 0
    xfer(0, 16'h4000);
    check("t1_pot0_a", 32'(dut.pot[0]), 32'h4000);
    check("t1_nospike", 32'(spike_valid), 32'd0);
    xfer(0, 16'h4000);
    check("t1_spike", 32'(spike_valid), 32'd1);
    check("t1_id", 32'(spike_id), 32'd0);
    check("t1_pot0_b", 32'(dut.pot[0]), 32'h0);
    spike_ready = 1'b1;
    tick();
    check("t1_drain", 32'(spike_valid), 32'd0);

    // 2: round robin from a fresh pointer
    do_reset();
    spike_ready = 1'b1;
    cur = {16'd1, 16'd1, 16'd1, 16'd1};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t2_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      tick();
      check("t2_upd_grant", 32'(grant), 32'd0);
      check("t2_upd_busy", 32'(busy), 32'd1);
      tick();
    end
    req = '0;
    check("t2_pot0", 32'(dut.pot[0]), 32'd2);
    check("t2_pot1", 32'(dut.pot[1]), 32'd1);
    check("t2_pot3", 32'(dut.pot[3]), 32'd1);

    // 3: saturation on neuron 1
    xfer(1, 16'h7FFE);
    check("t3_pot1_pre", 32'(dut.pot[1]), 32'h7FFF);
    check("t3_pre_nospike", 32'(spike_valid), 32'd0);
    spike_ready = 1'b0;
    xfer(1, 16'hFFFF);
    check("t3_spike", 32'(spike_valid), 32'd1);
    check("t3_id", 32'(spike_id), 32'd1);
    check("t3_pot1", 32'(dut.pot[1]), 32'h0);

    // 4: backpressure with spike from neuron 1 pending
    req[2] = 1'b1;
    cur[32 +: 16] = 16'd5;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_bp_grant", 32'(grant), 32'd0);
      check("t4_bp_id", 32'(spike_id), 32'd1);
      check("t4_bp_valid", 32'(spike_valid), 32'd1);
      tick();
    end
    spike_ready = 1'b1;
    #1;
    check("t4_grant_on_ready", 32'(grant), 32'b0100);
    tick();
    req[2] = 1'b0;
    check("t4_handshake", 32'(spike_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    tick();
    check("t4_pot2", 32'(dut.pot[2]), 32'd6);

    // 5: clear_pot aborts an in-flight UPDATE that would have fired
    xfer(3, 16'h6FFF);
    check("t5_pot3_pre", 32'(dut.pot[3]), 32'h7000);
    req[3] = 1'b1;
    cur[48 +: 16] = 16'h2000;
    #1;
    check("t5_grant", 32'(grant), 32'b1000);
    tick();
    req[3] = 1'b0;
    clear_pot = 1'b1;
    check("t5_in_update", 32'(busy), 32'd1);
    tick();
    clear_pot = 1'b0;
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_nospike", 32'(spike_valid), 32'd0);
    check("t5_pot3", 32'(dut.pot[3]), 32'h0);
    check("t5_pot0", 32'(dut.pot[0]), 32'h0);
    check("t5_pot2", 32'(dut.pot[2]), 32'h0);

    // clear_pot suppresses a grant in IDLE; dropping req without grant is legal
    req[0] = 1'b1;
    clear_pot = 1'b1;
    #1;
    check("clr_nogrant", 32'(grant), 32'd0);
    clear_pot = 1'b0;
    #1;
    check("clr_grant_back", 32'(grant), 32'b0001);
    req[0] = 1'b0;
    #1;
    check("drop_req", 32'(grant), 32'd0);

    // 6: four 0x8000 transfers on neuron 0
    do_reset();
    spike_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_spk;
`ifdef SNN_REFRACTORY_EN
      exp_spk = (k == 0 || k == 3);
`else
      exp_spk = 1'b1;
`endif
      xfer(0, 16'h8000);
      check("t6_spike", 32'(spike_valid), 32'(exp_spk));
      check("t6_pot0", 32'(dut.pot[0]), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
